// File: rtl/l0_skew_fifo.sv
`default_nettype none
// ============================================================================
// l0_skew_fifo : per-row L0 input FIFOs for the systolic MAC array, with
//                diagonally skewed or parallel read waves.
// Revision     : 1.0
// ============================================================================
module l0_skew_fifo #(
  parameter int row       = 8,
  parameter int bw        = 4,
  parameter int depth     = 64,
  parameter int af_margin = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [row*bw-1:0] in,
  input  logic              wr,
  input  logic              rd,
  input  logic              mode,
  output logic [row*bw-1:0] out,
  output logic [row-1:0]    o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);
  localparam logic [CW-1:0] AF_CNT   = CW'(depth - af_margin);

  logic [row-1:0] lane_full;
  logic [row-1:0] lane_af;
  logic [row-1:0] lane_empty;
  logic [row-1:0] rd_en_q;
  logic [row-1:0] rd_en_d;
  logic           wr_ok;
  logic           overflow_q;
  logic           overflow_d;
  logic           underflow_q;
  logic           underflow_d;

  assign o_full        = |lane_full;
  assign o_ready       = ~o_full;
  assign o_empty       = &lane_empty;
  assign o_almost_full = |lane_af;
  assign o_overflow    = overflow_q;
  assign o_underflow   = underflow_q;

  // Whole vectors only: a write is dropped if any single lane is full.
  assign wr_ok = wr & o_ready;

  always_comb begin
    rd_en_d = {rd_en_q[row-2:0], rd};
    if (mode) begin
      rd_en_d = {row{rd}};
    end
  end

  assign overflow_d  = overflow_q  | (wr & o_full);
  assign underflow_d = underflow_q | (|(rd_en_q & lane_empty));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_en_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_en_q     <= rd_en_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  for (genvar i = 0; i < row; i++) begin : g_lane
    logic [bw-1:0] mem [depth];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [bw-1:0] data_q;
    logic          valid_q;
    logic          pop;

    assign lane_full[i]  = (cnt_q == FULL_CNT);
    assign lane_af[i]    = (cnt_q >= AF_CNT);
    assign lane_empty[i] = (cnt_q == '0);
    assign pop           = rd_en_q[i] & ~lane_empty[i];
    assign cnt_d         = cnt_q + CW'(wr_ok) - CW'(pop);

    assign out[i*bw +: bw] = data_q;
    assign o_valid[i]      = valid_q;

    // Storage is deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
      if (reset && wr_ok) begin
        mem[wr_ptr_q] <= in[i*bw +: bw];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        data_q   <= '0;
        valid_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        valid_q <= pop;
        if (wr_ok) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          data_q   <= mem[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l0_skew_fifo.sv
`default_nettype none
// ============================================================================
// tb_l0_skew_fifo : directed self-checking bench for l0_skew_fifo.
// Revision        : 1.0
// ============================================================================
module tb_l0_skew_fifo;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [ROW*BW-1:0] in;
  logic              wr;
  logic              rd;
  logic              mode;
  logic [ROW*BW-1:0] out;
  logic [ROW-1:0]    o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_empty;
  logic              o_almost_full;
  logic              o_overflow;
  logic              o_underflow;

  int n_vec = 0;
  int n_err = 0;

  l0_skew_fifo #(.row(ROW), .bw(BW), .depth(DEPTH), .af_margin(4)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .mode(mode),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .o_empty(o_empty), .o_almost_full(o_almost_full),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] lane_of(input logic [ROW*BW-1:0] v, input int i);
    return v[i*BW +: BW];
  endfunction

  task automatic do_reset;
    reset = 1'b0; wr = 1'b0; rd = 1'b0;
    tick; tick;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    logic [11:0] got;
    logic [11:0] exp;
    mode = 1'b0;
    for (int c = 0; c < 30; c++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      in = $urandom;
      tick;
    end
    do_reset;
    got = {o_empty, o_ready, o_full, o_almost_full, o_overflow, o_underflow, 6'd0};
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_flags: got %b expected %b", got, exp);
    end
    n_vec++;
    if (out !== '0) begin
      n_err++; $display("FAIL reset_out: got %h expected %h", out, 32'h0);
    end
    n_vec++;
    if (o_valid !== '0) begin
      n_err++; $display("FAIL reset_valid: got %b expected %b", o_valid, 8'h0);
    end
  endtask

  task automatic test_skew;
    logic [ROW-1:0] ev;
    int k;
    mode = 1'b0; rd = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < ROW; i++) in[i*BW +: BW] = BW'(3*v + i);
      wr = 1'b1;
      tick;
    end
    wr = 1'b0;
    for (int c = 0; c < ROW + 4; c++) begin
      rd = (c < 3);
      tick;
      ev = '0;
      for (int i = 0; i < ROW; i++) begin
        k = c - 1 - i;
        if (k >= 0 && k <= 2) begin
          ev[i] = 1'b1;
          n_vec++;
          if (lane_of(out, i) !== BW'(3*k + i)) begin
            n_err++;
            $display("FAIL skew_data c=%0d lane=%0d: got %h expected %h", c, i, lane_of(out, i), BW'(3*k + i));
          end
        end
      end
      n_vec++;
      if (o_valid !== ev) begin
        n_err++; $display("FAIL skew_valid c=%0d: got %b expected %b", c, o_valid, ev);
      end
    end
    n_vec++;
    if (o_empty !== 1'b1 || o_underflow !== 1'b0) begin
      n_err++; $display("FAIL skew_end: got empty=%b uf=%b expected empty=1 uf=0", o_empty, o_underflow);
    end
  endtask

  task automatic test_parallel;
    logic [ROW-1:0] ev;
    mode = 1'b1; rd = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < ROW; i++) in[i*BW +: BW] = BW'(3*v + i);
      wr = 1'b1;
      tick;
    end
    wr = 1'b0;
    for (int c = 0; c < ROW + 4; c++) begin
      rd = (c < 3);
      tick;
      ev = (c >= 1 && c <= 3) ? '1 : '0;
      if (c >= 1 && c <= 3) begin
        for (int i = 0; i < ROW; i++) begin
          n_vec++;
          if (lane_of(out, i) !== BW'(3*(c-1) + i)) begin
            n_err++;
            $display("FAIL par_data c=%0d lane=%0d: got %h expected %h", c, i, lane_of(out, i), BW'(3*(c-1) + i));
          end
        end
      end
      n_vec++;
      if (o_valid !== ev) begin
        n_err++; $display("FAIL par_valid c=%0d: got %b expected %b", c, o_valid, ev);
      end
    end
    n_vec++;
    if (o_empty !== 1'b1 || o_underflow !== 1'b0) begin
      n_err++; $display("FAIL par_end: got empty=%b uf=%b expected empty=1 uf=0", o_empty, o_underflow);
    end
    mode = 1'b0;
  endtask

  task automatic test_full;
    int nxt [ROW];
    mode = 1'b0; rd = 1'b0;
    for (int n = 1; n <= DEPTH; n++) begin
      for (int i = 0; i < ROW; i++) in[i*BW +: BW] = BW'(n - 1 + i);
      wr = 1'b1;
      tick;
      n_vec++;
      if (o_almost_full !== (n >= 60) || o_full !== (n == DEPTH) || o_ready !== (n != DEPTH)) begin
        n_err++;
        $display("FAIL fill n=%0d: got af=%b full=%b ready=%b expected af=%b full=%b ready=%b",
                 n, o_almost_full, o_full, o_ready, (n >= 60), (n == DEPTH), (n != DEPTH));
      end
    end
    in = '1;
    tick;
    wr = 1'b0;
    n_vec++;
    if (o_overflow !== 1'b1 || o_full !== 1'b1) begin
      n_err++; $display("FAIL overflow: got ov=%b full=%b expected ov=1 full=1", o_overflow, o_full);
    end
    for (int i = 0; i < ROW; i++) nxt[i] = 0;
    for (int c = 0; c < DEPTH + ROW + 2; c++) begin
      rd = (c < DEPTH);
      tick;
      for (int i = 0; i < ROW; i++) begin
        if (o_valid[i]) begin
          n_vec++;
          if (lane_of(out, i) !== BW'(nxt[i] + i)) begin
            n_err++;
            $display("FAIL drain_data lane=%0d idx=%0d: got %h expected %h", i, nxt[i], lane_of(out, i), BW'(nxt[i] + i));
          end
          nxt[i]++;
        end
      end
    end
    for (int i = 0; i < ROW; i++) begin
      n_vec++;
      if (nxt[i] !== DEPTH) begin
        n_err++; $display("FAIL drain_count lane=%0d: got %0d expected %0d", i, nxt[i], DEPTH);
      end
    end
    n_vec++;
    if (o_ready !== 1'b1 || o_empty !== 1'b1 || o_underflow !== 1'b0) begin
      n_err++; $display("FAIL drain_end: got ready=%b empty=%b uf=%b expected 1 1 0", o_ready, o_empty, o_underflow);
    end
  endtask

  task automatic test_wrap;
    int nxt [ROW];
    do_reset;
    mode = 1'b0;
    for (int i = 0; i < ROW; i++) nxt[i] = 0;
    for (int c = 0; c < 200 + ROW + 3; c++) begin
      wr = (c < 200);
      rd = (c >= 1 && c <= 200);
      for (int i = 0; i < ROW; i++) in[i*BW +: BW] = BW'(c);
      tick;
      for (int i = 0; i < ROW; i++) begin
        if (o_valid[i]) begin
          n_vec++;
          if (lane_of(out, i) !== BW'(nxt[i])) begin
            n_err++;
            $display("FAIL wrap_data lane=%0d idx=%0d: got %h expected %h", i, nxt[i], lane_of(out, i), BW'(nxt[i]));
          end
          nxt[i]++;
        end
      end
    end
    for (int i = 0; i < ROW; i++) begin
      n_vec++;
      if (nxt[i] !== 200) begin
        n_err++; $display("FAIL wrap_count lane=%0d: got %0d expected 200", i, nxt[i]);
      end
    end
    n_vec++;
    if (o_overflow !== 1'b0 || o_underflow !== 1'b0 || o_empty !== 1'b1) begin
      n_err++; $display("FAIL wrap_flags: got ov=%b uf=%b empty=%b expected 0 0 1", o_overflow, o_underflow, o_empty);
    end
  endtask

  task automatic test_underflow_and_midreset;
    do_reset;
    mode = 1'b0;
    rd = 1'b1;
    tick;
    rd = 1'b0;
    for (int c = 0; c < ROW + 2; c++) begin
      tick;
      n_vec++;
      if (o_valid !== '0) begin
        n_err++; $display("FAIL empty_read_valid c=%0d: got %b expected %b", c, o_valid, 8'h0);
      end
    end
    n_vec++;
    if (o_underflow !== 1'b1 || o_overflow !== 1'b0) begin
      n_err++; $display("FAIL underflow: got uf=%b ov=%b expected uf=1 ov=0", o_underflow, o_overflow);
    end

    do_reset;
    for (int v = 0; v < 4; v++) begin
      in = {ROW{BW'(v + 5)}};
      wr = 1'b1;
      tick;
    end
    wr = 1'b0;
    rd = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    rd = 1'b0;
    for (int c = 0; c < ROW + 3; c++) begin
      n_vec++;
      if (o_valid !== '0 || o_empty !== 1'b1) begin
        n_err++; $display("FAIL midreset c=%0d: got valid=%b empty=%b expected valid=00000000 empty=1", c, o_valid, o_empty);
      end
      tick;
    end
  endtask

  initial begin
    reset = 1'b0; wr = 1'b0; rd = 1'b0; mode = 1'b0; in = '0;
    do_reset;
    test_reset;
    test_skew;
    test_parallel;
    test_full;
    test_wrap;
    test_underflow_and_midreset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
